// File: rtl/wb_trace_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_trace_pkg : shared defaults and derived widths for the writeback trace buffer
// Rev 1.0
// ---------------------------------------------------------------------------
package wb_trace_pkg;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_DEPTH        = 16;
    localparam int DEF_STALL_MARGIN = 3;
    localparam int DEF_TS_W         = 16;
    localparam int PTR_W            = $clog2(DEF_DEPTH);
    localparam int CNT_W            = PTR_W + 1;
endpackage
`default_nettype wire

// File: rtl/wb_trace_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_trace_ram : DEPTH x WIDTH register array, one write port, one registered read port
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_trace_ram
    import wb_trace_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule
`default_nettype wire

// File: rtl/wb_trace_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_trace_buf : circular capture FIFO for the core writeback stream with stall back-pressure.
// Optional timestamps via `WB_TRACE_TS_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module wb_trace_buf
    import wb_trace_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int STALL_MARGIN = DEF_STALL_MARGIN
`ifdef WB_TRACE_TS_EN
    ,
    parameter int TS_W         = DEF_TS_W
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     stall,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
`ifdef WB_TRACE_TS_EN
    output logic [TS_W-1:0]          rd_ts,
`endif
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - STALL_MARGIN);
`ifdef WB_TRACE_TS_EN
    localparam int MEM_W = DATA_W + TS_W;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;
    logic             drop;
    logic [CW-1:0]    count_next;
    logic [MEM_W-1:0] wr_word;
    logic [MEM_W-1:0] rd_word;

    always_comb begin
        wr_acc     = wb_valid && !full;
        rd_acc     = rd_en && !empty;
        drop       = wb_valid && full;
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            stall    <= 1'b0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_next;
            empty    <= (count_next == '0);
            full     <= (count_next == FULL_CNT);
            stall    <= (count_next >= STALL_CNT);
            rd_valid <= rd_acc;
            // A drop in the same cycle as clr_ovf keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef WB_TRACE_TS_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    assign wr_word = {ts_cnt, wb_data};
    assign rd_data = rd_word[DATA_W-1:0];
    assign rd_ts   = rd_word[MEM_W-1:DATA_W];
`else
    assign wr_word = wb_data;
    assign rd_data = rd_word;
`endif

    wb_trace_ram #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_word),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );
endmodule
`default_nettype wire

// File: tb/tb_wb_trace_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_trace_buf : self-checking bench for wb_trace_buf against a queue model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_wb_trace_buf;
    localparam int DEPTH        = 16;
    localparam int STALL_MARGIN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        rd_en;
    logic        clr_ovf;
    logic        stall;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        overflow;
`ifdef WB_TRACE_TS_EN
    logic [15:0] rd_ts;
`endif

    wb_trace_buf dut (
        .clk      (clk),
        .rst      (rst),
        .wb_valid (wb_valid),
        .wb_data  (wb_data),
        .stall    (stall),
        .rd_en    (rd_en),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
`ifdef WB_TRACE_TS_EN
        .rd_ts    (rd_ts),
`endif
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: contents as a queue, timestamps in a parallel queue
    logic [31:0] mq[$];
    logic [15:0] mts_q[$];
    logic        m_ovf;
    logic        m_rv;
    logic [31:0] m_rd;
    logic [15:0] m_rts;
    logic [15:0] m_ts;

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        re;
        logic        co;
        int          e_cnt;
        logic        e_rv;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},    32'(count),    32'(mq.size()));
        chk({tag, ".empty"},    32'(empty),    32'(mq.size() == 0));
        chk({tag, ".full"},     32'(full),     32'(mq.size() == DEPTH));
        chk({tag, ".stall"},    32'(stall),    32'(mq.size() >= DEPTH - STALL_MARGIN));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_rv));
        chk({tag, ".rd_data"},  rd_data,       m_rd);
`ifdef WB_TRACE_TS_EN
        chk({tag, ".rd_ts"},    32'(rd_ts),    32'(m_rts));
`endif
    endtask

    task automatic cycle(input logic wv, input logic [31:0] wd, input logic re,
                         input logic co, input string tag);
        bit was_full;
        bit was_empty;
        wb_valid  = wv;
        wb_data   = wd;
        rd_en     = re;
        clr_ovf   = co;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        m_rv = 1'b0;
        if (re && !was_empty) begin
            m_rd  = mq.pop_front();
            m_rts = mts_q.pop_front();
            m_rv  = 1'b1;
        end
        if (wv && !was_full) begin
            mq.push_back(wd);
            mts_q.push_back(m_ts);
        end
        if (wv && was_full) m_ovf = 1'b1;
        else if (co)        m_ovf = 1'b0;
        m_ts = m_ts + 16'd1;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        wb_valid = 1'b0;
        wb_data  = '0;
        rd_en    = 1'b0;
        clr_ovf  = 1'b0;
        rst      = 1'b1;
        #2;
        mq.delete();
        mts_q.delete();
        m_ovf = 1'b0;
        m_rv  = 1'b0;
        m_rd  = '0;
        m_rts = '0;
        m_ts  = '0;
        check_all("reset");
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int next_exp;
        int wp;
        int rp;

        do_reset();

        // Reset mid-fill
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0, "fill");
        chk("midfill.count", 32'(count), 32'd5);
        do_reset();
        chk("midfill.reset.count", 32'(count), 32'd0);
        chk("midfill.reset.empty", 32'(empty), 32'd1);

        // Table: empty read, simultaneous read/write at count 3, hold on empty read
        tbl[0]  = '{1'b0, 32'h0,  1'b1, 1'b0, 0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 2, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 32'hA3, 1'b0, 1'b0, 3, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 32'hA4, 1'b1, 1'b0, 3, 1'b1, 32'hA1};
        tbl[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 2, 1'b1, 32'hA2};
        tbl[6]  = '{1'b0, 32'h0,  1'b0, 1'b0, 2, 1'b0, 32'hA2};
        tbl[7]  = '{1'b1, 32'hA5, 1'b1, 1'b1, 2, 1'b1, 32'hA3};
        tbl[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1, 1'b1, 32'hA4};
        tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 0, 1'b1, 32'hA5};
        tbl[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 0, 1'b0, 32'hA5};
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].wv, tbl[i].wd, tbl[i].re, tbl[i].co, "vec");
            chk("vec.count",    32'(count),    32'(tbl[i].e_cnt));
            chk("vec.rd_valid", 32'(rd_valid), 32'(tbl[i].e_rv));
            chk("vec.rd_data",  rd_data,       tbl[i].e_rd);
        end

        // Ordering and pointer wrap
        do_reset();
        next_exp = 1;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 32'(i), 1'(i % 2 == 0), 1'b0, "order");
            if (rd_valid) begin
                chk("order.data", rd_data, 32'(next_exp));
                next_exp++;
            end
        end
        for (int k = 0; k < 40 && next_exp <= 20; k++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0, "drain");
            if (rd_valid) begin
                chk("order.data", rd_data, 32'(next_exp));
                next_exp++;
            end
        end
        chk("order.n", 32'(next_exp), 32'd21);
        chk("order.ovf", 32'(overflow), 32'd0);

        // Stall threshold
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cycle(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, "stallw");
            if (i == 11) chk("stall.12", 32'(stall), 32'd0);
        end
        chk("stall.13", 32'(stall), 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, "stallr");
        chk("stall.rel", 32'(stall), 32'd0);

        // Overflow, clear, drop-wins, read does not rescue a drop
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, "ovfw");
            if (i == 15) chk("ovf.16", 32'(overflow), 32'd0);
        end
        chk("ovf.full", 32'(full), 32'd1);
        chk("ovf.set", 32'(overflow), 32'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, "clr");
        chk("ovf.clr", 32'(overflow), 32'd0);
        cycle(1'b1, 32'hBAD, 1'b0, 1'b1, "dropwins");
        chk("ovf.dropwins", 32'(overflow), 32'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, "clr2");
        cycle(1'b1, 32'hDEAD, 1'b1, 1'b0, "norescue");
        chk("ovf.norescue", 32'(overflow), 32'd1);
        chk("ovf.rd0", rd_data, 32'h100);
        for (int i = 1; i < 16; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0, "ovfr");
            chk("ovf.rd", rd_data, 32'h100 + 32'(i));
        end
        chk("ovf.empty", 32'(empty), 32'd1);

`ifdef WB_TRACE_TS_EN
        // Timestamps captured at cycles 10, 11, 20 after reset
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            cycle(1'(k == 10 || k == 11 || k == 20), 32'hA00 + 32'(k), 1'b0, 1'b0, "tsw");
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0, "tsr");
        chk("ts.0", 32'(rd_ts), 32'd10);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, "tsr");
        chk("ts.1", 32'(rd_ts), 32'd11);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, "tsr");
        chk("ts.2", 32'(rd_ts), 32'd20);
`endif

        // Randomized phases with varying write/read pressure
        do_reset();
        wp = 50;
        rp = 50;
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) begin
                wp = int'($urandom_range(0, 100));
                rp = int'($urandom_range(0, 100));
            end
            cycle(1'(int'($urandom_range(0, 99)) < wp), $urandom,
                  1'(int'($urandom_range(0, 99)) < rp), 1'($urandom_range(0, 39) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
